// File: rtl/plic_target_ctrl.sv
// Single-target PLIC core: pending/in-flight tracking, arbitration, claim/complete.
// Optional `PLIC_ERR_FLAG_EN adds a sticky err_o flag for ignored completions.
module plic_target_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_pend_i,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio_i,
    input  logic [NUM_SRC-1:0]        src_en_i,
    input  logic [PRIO_W-1:0]         threshold_i,
    input  logic                      claim_req_i,
    output logic                      claim_ack_o,
    output logic [ID_W-1:0]           claim_id_o,
    input  logic                      complete_req_i,
    input  logic [ID_W-1:0]           complete_wdata_i,
    output logic [ID_W-1:0]           complete_id_o,
    output logic                      irq_o
`ifdef PLIC_ERR_FLAG_EN
    ,
    output logic                      err_o
`endif
);

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] act_q, act_d;
    logic [ID_W-1:0]    best_id_q, best_id_d;
    logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
    logic               claim_ack_q;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;
    logic [ID_W-1:0]    compl_id_q, compl_id_d;
    logic               claim_hit;
    logic               compl_ok;

    // Descending scan with >= leaves the lowest ID among equal priorities.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (pend_q[k] && src_en_i[k] &&
                src_prio_i[k*PRIO_W +: PRIO_W] != '0 &&
                src_prio_i[k*PRIO_W +: PRIO_W] >= best_prio_d) begin
                best_id_d   = ID_W'(k + 1);
                best_prio_d = src_prio_i[k*PRIO_W +: PRIO_W];
            end
        end
        if (claim_req_i) begin
            best_id_d   = '0;
            best_prio_d = '0;
        end
    end

    always_comb begin
        claim_hit = claim_req_i && (best_prio_q > threshold_i);
        compl_ok  = 1'b0;
        pend_d    = pend_q;
        act_d     = act_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (complete_req_i && act_q[k] &&
                complete_wdata_i == ID_W'(k + 1)) begin
                compl_ok = 1'b1;
                act_d[k] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (claim_hit && best_id_q == ID_W'(k + 1)) begin
                pend_d[k] = 1'b0;
                act_d[k]  = 1'b1;
            end
        end
        pend_d     = pend_d | src_pend_i;
        claim_id_d = claim_hit ? best_id_q : '0;
        compl_id_d = compl_ok ? complete_wdata_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            act_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            claim_ack_q <= 1'b0;
            claim_id_q  <= '0;
            compl_id_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            act_q       <= act_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            claim_ack_q <= claim_req_i;
            claim_id_q  <= claim_id_d;
            compl_id_q  <= compl_id_d;
        end
    end

`ifdef PLIC_ERR_FLAG_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (complete_req_i && !compl_ok) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`endif

    assign claim_ack_o   = claim_ack_q;
    assign claim_id_o    = claim_id_q;
    assign complete_id_o = compl_id_q;
    assign irq_o         = best_prio_q > threshold_i;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Randomised + directed bench for plic_target_ctrl against a behavioural model.
// Compare process checks every cycle at the falling edge.
module tb_plic_target_ctrl;
    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 5;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_SRC-1:0]        src_pend_i = '0;
    logic [NUM_SRC*PRIO_W-1:0] src_prio_i = '0;
    logic [NUM_SRC-1:0]        src_en_i = '1;
    logic [PRIO_W-1:0]         threshold_i = '0;
    logic                      claim_req_i = 1'b0;
    logic                      claim_ack_o;
    logic [ID_W-1:0]           claim_id_o;
    logic                      complete_req_i = 1'b0;
    logic [ID_W-1:0]           complete_wdata_i = '0;
    logic [ID_W-1:0]           complete_id_o;
    logic                      irq_o;
`ifdef PLIC_ERR_FLAG_EN
    logic                      err_o;
`endif

    plic_target_ctrl #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_pend_i(src_pend_i), .src_prio_i(src_prio_i),
        .src_en_i(src_en_i), .threshold_i(threshold_i),
        .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o),
        .claim_id_o(claim_id_o), .complete_req_i(complete_req_i),
        .complete_wdata_i(complete_wdata_i),
        .complete_id_o(complete_id_o), .irq_o(irq_o)
`ifdef PLIC_ERR_FLAG_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string n, input int a, input int e);
        total_cnt++;
        if (a == e) pass_cnt++;
        else $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    endtask

    // Behavioural model: sets of pending/in-flight IDs and the latched winner.
    bit [NUM_SRC-1:0] m_pend, m_act;
    int m_bid, m_bprio, m_ack, m_cid, m_comp, m_err;

    function automatic int prio_of(input int id);
        return int'(src_prio_i[(id-1)*PRIO_W +: PRIO_W]);
    endfunction

    function automatic void pick(input bit [NUM_SRC-1:0] p,
                                 output int id, output int pr);
        id = 0;
        pr = 0;
        for (int lv = (1 << PRIO_W) - 1; lv >= 1; lv--)
            for (int s = 1; s <= NUM_SRC; s++)
                if (id == 0 && p[s-1] && src_en_i[s-1] && prio_of(s) == lv) begin
                    id = s;
                    pr = lv;
                end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_act = '0; m_bid = 0; m_bprio = 0;
            m_ack = 0; m_cid = 0; m_comp = 0; m_err = 0;
        end else begin
            bit [NUM_SRC-1:0] np, na;
            int w, nid, npr;
            bit hit, cv;
            np = m_pend;
            na = m_act;
            w = int'(complete_wdata_i);
            hit = claim_req_i && (m_bprio > int'(threshold_i));
            cv = complete_req_i && w >= 1 && w <= NUM_SRC && m_act[w-1];
            if (cv) na[w-1] = 1'b0;
            if (hit && m_bid != 0) begin
                np[m_bid-1] = 1'b0;
                na[m_bid-1] = 1'b1;
            end
            np = np | src_pend_i;
            pick(m_pend, nid, npr);
            if (claim_req_i) begin nid = 0; npr = 0; end
            m_ack = claim_req_i ? 1 : 0;
            m_cid = hit ? m_bid : 0;
            m_comp = cv ? w : 0;
            if (complete_req_i && !cv) m_err = 1;
            m_pend = np; m_act = na; m_bid = nid; m_bprio = npr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack", int'(claim_ack_o), m_ack);
            chk("claim_id", int'(claim_id_o), m_cid);
            chk("complete_id", int'(complete_id_o), m_comp);
            chk("irq", int'(irq_o), (m_bprio > int'(threshold_i)) ? 1 : 0);
`ifdef PLIC_ERR_FLAG_EN
            chk("err", int'(err_o), m_err);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int id, input int p);
        src_prio_i[(id-1)*PRIO_W +: PRIO_W] = PRIO_W'(p);
    endtask

    task automatic claim();
        claim_req_i = 1'b1;
        cyc();
        claim_req_i = 1'b0;
    endtask

    task automatic compl(input int id);
        complete_req_i = 1'b1;
        complete_wdata_i = ID_W'(id);
        cyc();
        complete_req_i = 1'b0;
        complete_wdata_i = '0;
    endtask

    task automatic chk_zero_outs(input string n);
        chk({n, "_ack"}, int'(claim_ack_o), 0);
        chk({n, "_cid"}, int'(claim_id_o), 0);
        chk({n, "_comp"}, int'(complete_id_o), 0);
        chk({n, "_irq"}, int'(irq_o), 0);
    endtask

    initial begin
        repeat (3) cyc();
        chk_zero_outs("reset");
        rst_n = 1'b1;
        cyc();

        // Single source: 2-cycle irq latency, claim, complete.
        setp(3, 3); threshold_i = 3'd1;
        src_pend_i = 8'b0000_0100;
        cyc();
        src_pend_i = '0;
        chk("t1_irq_early", int'(irq_o), 0);
        cyc();
        chk("t1_irq", int'(irq_o), 1);
        claim();
        chk("t1_ack", int'(claim_ack_o), 1);
        chk("t1_cid", int'(claim_id_o), 3);
        chk("t1_irq_low", int'(irq_o), 0);
        cyc();
        chk("t1_ack_off", int'(claim_ack_o), 0);
        compl(3);
        chk("t1_comp", int'(complete_id_o), 3);
        cyc();
        chk("t1_comp_off", int'(complete_id_o), 0);
        setp(3, 0);

        // Equal priority tie goes to lowest ID.
        setp(2, 4); setp(5, 4);
        src_pend_i = 8'b0001_0010;
        cyc();
        src_pend_i = '0;
        cyc();
        claim();
        chk("t2_cid_a", int'(claim_id_o), 2);
        cyc();
        claim();
        chk("t2_cid_b", int'(claim_id_o), 5);
        compl(2);
        compl(5);
        setp(2, 0); setp(5, 0);

        // Priority equal to threshold never interrupts.
        setp(4, 2); threshold_i = 3'd2;
        src_pend_i = 8'b0000_1000;
        cyc();
        src_pend_i = '0;
        cyc();
        cyc();
        chk("t3_irq", int'(irq_o), 0);
        claim();
        chk("t3_ack", int'(claim_ack_o), 1);
        chk("t3_cid", int'(claim_id_o), 0);
        cyc();
        setp(4, 3);
        cyc();
        chk("t3_irq_up", int'(irq_o), 1);
        claim();
        chk("t3_cid_up", int'(claim_id_o), 4);
        compl(4);
        setp(4, 0);

        // Ignored completions.
        compl(6);
        chk("t4_c6", int'(complete_id_o), 0);
        compl(0);
        chk("t4_c0", int'(complete_id_o), 0);
        compl(NUM_SRC + 1);
        chk("t4_c9", int'(complete_id_o), 0);
`ifdef PLIC_ERR_FLAG_EN
        chk("t4_err", int'(err_o), 1);
`endif

        // Set wins over claim-clear on the same bit.
        setp(2, 5);
        src_pend_i = 8'b0000_0010;
        cyc();
        src_pend_i = '0;
        cyc();
        src_pend_i = 8'b0000_0010;
        claim();
        src_pend_i = '0;
        chk("t5_cid", int'(claim_id_o), 2);
        cyc();
        claim();
        chk("t5_cid_again", int'(claim_id_o), 2);
        compl(2);
        chk("t5_comp", int'(complete_id_o), 2);
        setp(2, 0);

        // Async reset drops pending and in-flight state.
        setp(1, 6);
        src_pend_i = 8'b0000_0001;
        cyc();
        src_pend_i = '0;
        cyc();
        src_pend_i = 8'b0000_0100;
        claim();
        src_pend_i = '0;
        chk("t6_cid", int'(claim_id_o), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero_outs("t6_rst");
        cyc();
        rst_n = 1'b1;
        cyc();
        compl(1);
        chk("t6_comp", int'(complete_id_o), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int q[$];
            if (i % 40 == 0) begin
                for (int s = 1; s <= NUM_SRC; s++) setp(s, $urandom_range(0, 7));
                src_en_i = NUM_SRC'($urandom);
                threshold_i = PRIO_W'($urandom_range(0, 4));
            end
            for (int s = 0; s < NUM_SRC; s++)
                src_pend_i[s] = ($urandom_range(0, 15) == 0);
            claim_req_i = ($urandom_range(0, 4) == 0);
            complete_req_i = ($urandom_range(0, 3) == 0);
            for (int s = 1; s <= NUM_SRC; s++) if (m_act[s-1]) q.push_back(s);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                complete_wdata_i = ID_W'(q[$urandom_range(0, q.size() - 1)]);
            else
                complete_wdata_i = ID_W'($urandom_range(0, NUM_SRC + 1));
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc();
        end
        src_pend_i = '0;
        claim_req_i = 1'b0;
        complete_req_i = 1'b0;
        cyc();
        cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
